// File: rtl/cap_pkg.sv
// Shared types and constants for the capture trigger controller.
// Trigger-source bit positions index trig_src_en and the hit vector.
package cap_pkg;
   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} cap_state_t;
   localparam int TRIG_SPI  = 0;
   localparam int TRIG_UART = 1;
   localparam int TRIG_EXT  = 2;
endpackage

// File: rtl/capture_trig_ctrl_if.sv
// Sample-RAM write port: the controller drives it, the RAM consumes it.
// No backpressure; the RAM accepts one write per cycle.
interface capture_trig_ctrl_if #(parameter int ADDR_W = 9);
   logic              wr_en;
   logic [ADDR_W-1:0] waddr;
   modport master (output wr_en, output waddr);
   modport slave  (input  wr_en, input  waddr);
endinterface

// File: rtl/cap_addr_cnt.sv
// Wrapping write-address counter; clear has priority over increment.
// Registered output, updates the cycle after clr/inc; no backpressure.
module cap_addr_cnt #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr
);
   logic [ADDR_W-1:0] addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   addr_q <= '0;
      else if (clr) addr_q <= '0;
      else if (inc) addr_q <= addr_q + ADDR_W'(1);
   end

   assign addr = addr_q;
endmodule

// File: rtl/capture_trig_ctrl.sv
// Capture sequencer IDLE->PRE->ARMED->POST->DONE; status updates one cycle after the qualifying strobe.
// No backpressure: wr_en is combinational from smpl_en. Define CAP_AUTO_TRIG_EN to add the auto-trigger timeout.
module capture_trig_ctrl
   import cap_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arm,
   input  logic                       abort,
   input  logic                       smpl_en,
   input  logic [2:0]                 trig_src_en,
   input  logic                       SPItrig,
   input  logic                       UARTtrig,
   input  logic                       ext_trig,
   input  logic [ADDR_W-1:0]          trig_pos,
   input  logic [15:0]                auto_to,
   capture_trig_ctrl_if.master        ram,
   output logic [ADDR_W-1:0]          trig_addr,
   output logic                       armed,
   output logic                       triggered,
   output logic                       capture_done,
   output logic                       auto_trig
);
   cap_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
   logic [ADDR_W-1:0] trig_pos_l_q, trig_pos_l_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic              trig_pend_q, trig_pend_d;
   logic [ADDR_W-1:0] pre_tgt;
   logic [ADDR_W-1:0] waddr;
   logic [2:0]        src;
   logic              hit, auto_hit, wr, arm_start;

   assign src[TRIG_SPI]  = SPItrig;
   assign src[TRIG_UART] = UARTtrig;
   assign src[TRIG_EXT]  = ext_trig;
   assign hit = |(trig_src_en & src);

   assign wr = smpl_en & ~abort & ((state_q == PRE) | (state_q == ARMED) | (state_q == POST));
   assign arm_start = arm & ~abort & ((state_q == IDLE) | (state_q == DONE));
   // DEPTH - trig_pos_l, computed modulo DEPTH
   assign pre_tgt = '0 - trig_pos_l_q;

   cap_addr_cnt #(.ADDR_W(ADDR_W)) u_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (arm_start),
      .inc   (wr),
      .addr  (waddr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pre_cnt_q    <= '0;
         post_cnt_q   <= '0;
         trig_pos_l_q <= ADDR_W'(1);
         trig_addr_q  <= '0;
         trig_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         post_cnt_q   <= post_cnt_d;
         trig_pos_l_q <= trig_pos_l_d;
         trig_addr_q  <= trig_addr_d;
         trig_pend_q  <= trig_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      post_cnt_d   = post_cnt_q;
      trig_pos_l_d = trig_pos_l_q;
      trig_addr_d  = trig_addr_q;
      trig_pend_d  = trig_pend_q;
      if (abort) begin
         state_d     = IDLE;
         trig_pend_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  state_d      = PRE;
                  pre_cnt_d    = '0;
                  post_cnt_d   = '0;
                  trig_pend_d  = 1'b0;
                  trig_pos_l_d = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
               end
            end
            PRE: begin
               if (smpl_en) begin
                  pre_cnt_d = pre_cnt_q + ADDR_W'(1);
                  if (pre_cnt_d == pre_tgt) state_d = ARMED;
               end
            end
            ARMED: begin
               if (smpl_en && (hit || trig_pend_q || auto_hit)) begin
                  trig_addr_d = waddr;
                  post_cnt_d  = ADDR_W'(1);
                  trig_pend_d = 1'b0;
                  state_d     = (trig_pos_l_q == ADDR_W'(1)) ? DONE : POST;
               end else if (!smpl_en && hit) begin
                  trig_pend_d = 1'b1;
               end
            end
            POST: begin
               if (smpl_en) begin
                  post_cnt_d = post_cnt_q + ADDR_W'(1);
                  if (post_cnt_d == trig_pos_l_q) state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef CAP_AUTO_TRIG_EN
   logic [15:0] to_cnt_q, to_nxt;
   logic        auto_trig_q;

   assign to_nxt   = to_cnt_q + 16'd1;
   assign auto_hit = (state_q == ARMED) & smpl_en & ~abort & (auto_to != 16'd0) & (to_nxt == auto_to);

   // to_cnt sits at zero outside ARMED, so it is clear on entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q    <= '0;
         auto_trig_q <= 1'b0;
      end else begin
         if (state_q != ARMED)  to_cnt_q <= '0;
         else if (smpl_en)      to_cnt_q <= to_nxt;
         if (abort || arm_start)                      auto_trig_q <= 1'b0;
         else if (auto_hit && !(hit || trig_pend_q))  auto_trig_q <= 1'b1;
      end
   end

   assign auto_trig = auto_trig_q;
`else
   logic unused_auto_to;
   assign unused_auto_to = ^auto_to;
   assign auto_hit  = 1'b0;
   assign auto_trig = 1'b0;
`endif

   assign ram.wr_en    = wr;
   assign ram.waddr    = waddr;
   assign trig_addr    = trig_addr_q;
   assign armed        = (state_q == ARMED);
   assign triggered    = (state_q == POST) | (state_q == DONE);
   assign capture_done = (state_q == DONE);
endmodule

// File: tb/tb_capture_trig_ctrl.sv
// Directed bench for capture_trig_ctrl at ADDR_W=4 (DEPTH 16); expectations are hand-derived.
module tb_capture_trig_ctrl;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0, abort = 1'b0, smpl_en = 1'b0;
   logic          SPItrig = 1'b0, UARTtrig = 1'b0, ext_trig = 1'b0;
   logic [2:0]    trig_src_en = 3'b000;
   logic [AW-1:0] trig_pos = '0;
   logic [15:0]   auto_to = 16'd0;
   logic [AW-1:0] trig_addr;
   logic          armed, triggered, capture_done, auto_trig;
   int            total = 0;
   int            bad = 0;

   capture_trig_ctrl_if #(.ADDR_W(AW)) ram_if ();

   capture_trig_ctrl #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arm          (arm),
      .abort        (abort),
      .smpl_en      (smpl_en),
      .trig_src_en  (trig_src_en),
      .SPItrig      (SPItrig),
      .UARTtrig     (UARTtrig),
      .ext_trig     (ext_trig),
      .trig_pos     (trig_pos),
      .auto_to      (auto_to),
      .ram          (ram_if),
      .trig_addr    (trig_addr),
      .armed        (armed),
      .triggered    (triggered),
      .capture_done (capture_done),
      .auto_trig    (auto_trig)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [AW-1:0] tp);
      trig_pos = tp;
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic test_reset();
      smpl_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (ram_if.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", ram_if.wr_en); end
      total++; if (ram_if.waddr !== 4'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", ram_if.waddr); end
      total++; if (trig_addr !== 4'd0) begin bad++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr); end
      total++; if ({armed, triggered, capture_done, auto_trig} !== 4'b0000) begin bad++; $display("FAIL reset_status got=%b exp=0000", {armed, triggered, capture_done, auto_trig}); end
      smpl_en = 1'b0;
      rst_n = 1'b1;
      step();
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL idle_after_reset armed got=%b exp=0", armed); end
   endtask

   task automatic test_basic();
      trig_src_en = 3'b001;
      do_arm(4);
      total++; if (ram_if.waddr !== 4'd0 || armed !== 1'b0) begin bad++; $display("FAIL basic_pre waddr=%0d armed=%b exp 0/0", ram_if.waddr, armed); end
      for (int i = 0; i < 12; i++) begin
         smpl_en = 1'b1;
         step();
         total++; if (armed !== (i == 11)) begin bad++; $display("FAIL basic_arm_point write=%0d armed=%b exp=%b", i, armed, (i == 11)); end
      end
      repeat (8) step();
      total++; if (ram_if.waddr !== 4'd4 || triggered !== 1'b0) begin bad++; $display("FAIL basic_armed_wait waddr=%0d trg=%b exp 4/0", ram_if.waddr, triggered); end
      SPItrig = 1'b1;
      #1;
      total++; if (ram_if.wr_en !== 1'b1) begin bad++; $display("FAIL basic_wr_en got=%b exp=1", ram_if.wr_en); end
      step();
      SPItrig = 1'b0;
      total++; if (triggered !== 1'b1 || armed !== 1'b0 || trig_addr !== 4'd4) begin bad++; $display("FAIL basic_trig trg=%b armed=%b trig_addr=%0d exp 1/0/4", triggered, armed, trig_addr); end
      repeat (2) step();
      total++; if (capture_done !== 1'b0) begin bad++; $display("FAIL basic_post_early done=%b exp=0", capture_done); end
      step();
      total++; if (capture_done !== 1'b1 || ram_if.waddr !== 4'd8) begin bad++; $display("FAIL basic_done done=%b waddr=%0d exp 1/8", capture_done, ram_if.waddr); end
      #1;
      total++; if (ram_if.wr_en !== 1'b0) begin bad++; $display("FAIL done_no_write wr_en=%b exp=0", ram_if.wr_en); end
      step();
      smpl_en = 1'b0;
      total++; if (ram_if.waddr !== 4'd8 || capture_done !== 1'b1) begin bad++; $display("FAIL done_hold waddr=%0d done=%b exp 8/1", ram_if.waddr, capture_done); end
   endtask

   task automatic test_src_mask();
      trig_src_en = 3'b010;
      do_arm(4);
      smpl_en = 1'b1;
      repeat (12) step();
      total++; if (armed !== 1'b1 || ram_if.waddr !== 4'd0 + 4'd12) begin bad++; $display("FAIL mask_armed armed=%b waddr=%0d exp 1/12", armed, ram_if.waddr); end
      SPItrig = 1'b1;
      ext_trig = 1'b1;
      repeat (3) step();
      SPItrig = 1'b0;
      ext_trig = 1'b0;
      total++; if (armed !== 1'b1 || triggered !== 1'b0 || ram_if.waddr !== 4'd15) begin bad++; $display("FAIL mask_ignored armed=%b trg=%b waddr=%0d exp 1/0/15", armed, triggered, ram_if.waddr); end
      UARTtrig = 1'b1;
      step();
      UARTtrig = 1'b0;
      total++; if (triggered !== 1'b1 || trig_addr !== 4'd15) begin bad++; $display("FAIL mask_uart trg=%b trig_addr=%0d exp 1/15", triggered, trig_addr); end
      repeat (3) step();
      smpl_en = 1'b0;
      total++; if (capture_done !== 1'b1 || ram_if.waddr !== 4'd3) begin bad++; $display("FAIL mask_done done=%b waddr=%0d exp 1/3", capture_done, ram_if.waddr); end
   endtask

   task automatic test_pending();
      trig_src_en = 3'b010;
      do_arm(2);
      smpl_en = 1'b1;
      repeat (14) step();
      smpl_en = 1'b0;
      total++; if (armed !== 1'b1 || ram_if.waddr !== 4'd14) begin bad++; $display("FAIL pend_armed armed=%b waddr=%0d exp 1/14", armed, ram_if.waddr); end
      UARTtrig = 1'b1;
      step();
      UARTtrig = 1'b0;
      repeat (2) step();
      total++; if (armed !== 1'b1 || triggered !== 1'b0 || ram_if.waddr !== 4'd14) begin bad++; $display("FAIL pend_wait armed=%b trg=%b waddr=%0d exp 1/0/14", armed, triggered, ram_if.waddr); end
      smpl_en = 1'b1;
      step();
      smpl_en = 1'b0;
      total++; if (triggered !== 1'b1 || capture_done !== 1'b0 || trig_addr !== 4'd14) begin bad++; $display("FAIL pend_trig trg=%b done=%b trig_addr=%0d exp 1/0/14", triggered, capture_done, trig_addr); end
      smpl_en = 1'b1;
      step();
      smpl_en = 1'b0;
      total++; if (capture_done !== 1'b1 || ram_if.waddr !== 4'd0) begin bad++; $display("FAIL pend_done done=%b waddr=%0d exp 1/0", capture_done, ram_if.waddr); end
   endtask

   task automatic test_pre_abort();
      trig_src_en = 3'b001;
      do_arm(4);
      SPItrig = 1'b1;
      smpl_en = 1'b1;
      repeat (3) step();
      SPItrig = 1'b0;
      total++; if (armed !== 1'b0 || triggered !== 1'b0 || ram_if.waddr !== 4'd3) begin bad++; $display("FAIL pre_ignore armed=%b trg=%b waddr=%0d exp 0/0/3", armed, triggered, ram_if.waddr); end
      repeat (9) step();
      total++; if (armed !== 1'b1 || ram_if.waddr !== 4'd12) begin bad++; $display("FAIL pre_to_armed armed=%b waddr=%0d exp 1/12", armed, ram_if.waddr); end
      SPItrig = 1'b1;
      step();
      SPItrig = 1'b0;
      total++; if (triggered !== 1'b1 || trig_addr !== 4'd12) begin bad++; $display("FAIL pre_no_pend trg=%b trig_addr=%0d exp 1/12", triggered, trig_addr); end
      step();
      abort = 1'b1;
      #1;
      total++; if (ram_if.wr_en !== 1'b0) begin bad++; $display("FAIL abort_no_write wr_en=%b exp=0", ram_if.wr_en); end
      step();
      abort = 1'b0;
      total++; if ({armed, triggered, capture_done} !== 3'b000 || ram_if.waddr !== 4'd14) begin bad++; $display("FAIL abort_idle status=%b waddr=%0d exp 000/14", {armed, triggered, capture_done}, ram_if.waddr); end
      #1;
      total++; if (ram_if.wr_en !== 1'b0) begin bad++; $display("FAIL idle_no_write wr_en=%b exp=0", ram_if.wr_en); end
      smpl_en = 1'b0;
   endtask

   task automatic test_arm_abort_done();
      trig_src_en = 3'b001;
      do_arm(0);
      smpl_en = 1'b1;
      repeat (15) step();
      smpl_en = 1'b0;
      total++; if (armed !== 1'b1 || ram_if.waddr !== 4'd15) begin bad++; $display("FAIL tp0_armed armed=%b waddr=%0d exp 1/15", armed, ram_if.waddr); end
      do_arm(4);
      total++; if (armed !== 1'b1 || ram_if.waddr !== 4'd15) begin bad++; $display("FAIL arm_ignored armed=%b waddr=%0d exp 1/15", armed, ram_if.waddr); end
      SPItrig = 1'b1;
      smpl_en = 1'b1;
      step();
      SPItrig = 1'b0;
      smpl_en = 1'b0;
      total++; if (capture_done !== 1'b1 || trig_addr !== 4'd15 || ram_if.waddr !== 4'd0) begin bad++; $display("FAIL tp0_done done=%b trig_addr=%0d waddr=%0d exp 1/15/0", capture_done, trig_addr, ram_if.waddr); end
      arm = 1'b1;
      abort = 1'b1;
      step();
      arm = 1'b0;
      abort = 1'b0;
      total++; if ({armed, triggered, capture_done} !== 3'b000) begin bad++; $display("FAIL arm_abort status=%b exp=000", {armed, triggered, capture_done}); end
      smpl_en = 1'b1;
      #1;
      total++; if (ram_if.wr_en !== 1'b0) begin bad++; $display("FAIL arm_abort_idle wr_en=%b exp=0", ram_if.wr_en); end
      smpl_en = 1'b0;
   endtask

   task automatic test_auto();
      trig_src_en = 3'b000;
      auto_to = 16'd5;
      do_arm(4);
      smpl_en = 1'b1;
      repeat (12) step();
      total++; if (armed !== 1'b1) begin bad++; $display("FAIL auto_armed armed=%b exp=1", armed); end
      SPItrig = 1'b1;
      UARTtrig = 1'b1;
      ext_trig = 1'b1;
      repeat (4) step();
      SPItrig = 1'b0;
      UARTtrig = 1'b0;
      ext_trig = 1'b0;
      total++; if (armed !== 1'b1 || triggered !== 1'b0) begin bad++; $display("FAIL no_src_no_trig armed=%b trg=%b exp 1/0", armed, triggered); end
      step();
      smpl_en = 1'b0;
`ifdef CAP_AUTO_TRIG_EN
      total++; if (triggered !== 1'b1 || auto_trig !== 1'b1 || trig_addr !== 4'd0) begin bad++; $display("FAIL auto_fire trg=%b auto=%b trig_addr=%0d exp 1/1/0", triggered, auto_trig, trig_addr); end
`else
      total++; if (armed !== 1'b1 || auto_trig !== 1'b0) begin bad++; $display("FAIL auto_absent armed=%b auto=%b exp 1/0", armed, auto_trig); end
`endif
      abort = 1'b1;
      step();
      abort = 1'b0;
      auto_to = 16'd0;
      total++; if (auto_trig !== 1'b0 || armed !== 1'b0) begin bad++; $display("FAIL auto_abort auto=%b armed=%b exp 0/0", auto_trig, armed); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_src_mask();
      test_pending();
      test_pre_abort();
      test_arm_abort_done();
      test_auto();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
